// File: rtl/tow_pkg.sv
// ============================================================================
// tow_pkg : shared types for the player key conditioner   | Rev 1.0
// ============================================================================
`default_nettype none

package tow_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } key_state_t;

    // Raw buttons are active-low
    localparam logic KEY_PRESSED = 1'b0;

endpackage

`default_nettype wire

// File: rtl/key_channel.sv
// ============================================================================
// key_channel : one pushbutton -> synchronizer, debounce, single press pulse | Rev 1.0
// ============================================================================
`default_nettype none

module key_channel
    import tow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    input  logic clear,
    output logic press_pulse
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = '0;

    logic          sync1;
    logic          sync2;
    logic          pressed;
    key_state_t    state;
    key_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pulse_nxt;

    assign pressed = (sync2 == KEY_PRESSED);

    // Synchronizer is deliberately not cleared by nextRound: it only tracks the pin
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= ~KEY_PRESSED;
            sync2 <= ~KEY_PRESSED;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HELD;
            cnt         <= CNT_ZERO;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        if (clear) begin
            state_nxt = HELD;
            cnt_nxt   = CNT_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state_nxt = PRESS_CHK;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt   = CNT_ZERO;
                    end
                end
                PRESS_CHK: begin
                    if (!pressed) begin
                        state_nxt = IDLE;
                        cnt_nxt   = CNT_ZERO;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = HELD;
                        cnt_nxt   = CNT_ZERO;
                        pulse_nxt = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state_nxt = REL_CHK;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                REL_CHK: begin
                    if (pressed) begin
                        state_nxt = HELD;
                        cnt_nxt   = CNT_ZERO;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = IDLE;
                        cnt_nxt   = CNT_ZERO;
                    end else begin
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = HELD;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_press_conditioner.sv
// ============================================================================
// key_press_conditioner : raw L/R pushbuttons -> clean one-cycle press pulses | Rev 1.0
// ============================================================================
`default_nettype none

module key_press_conditioner
    import tow_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    input  logic nextRound,
    output logic L,
    output logic R
);

    // Channels are independent; simultaneous L and R are passed through unarbitrated
    key_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_left (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_l_n),
        .clear       (nextRound),
        .press_pulse (L)
    );

    key_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_right (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_r_n),
        .clear       (nextRound),
        .press_pulse (R)
    );

endmodule

`default_nettype wire
